// File: rtl/bisr_pkg.sv
// Shared types and helpers for the BISR recompute path.
// Holds the dispatcher state encoding and one-hot decode.
package bisr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } disp_state_t;

    localparam int RU_LAT_DEFAULT = 2;

    // Wide one-hot; callers size-cast down to their row/col count.
    function automatic logic [63:0] onehot(input logic [5:0] idx);
        onehot = 64'd1 << idx;
    endfunction

endpackage

// File: rtl/recompute_dispatcher.sv
// Routes one faulty PE's operands to the shared recompute unit
// and hands back the substituted result.
module recompute_dispatcher
    import bisr_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int RU_LAT    = RU_LAT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fault_valid,
    input  logic [$clog2(ROWS)-1:0]  fault_row,
    input  logic [$clog2(COLS)-1:0]  fault_col,
    output logic                     fault_ready,
    input  logic                     tap_valid,
    input  logic [$clog2(ROWS)-1:0]  tap_row,
    input  logic [$clog2(COLS)-1:0]  tap_col,
    input  logic [WORD_SIZE-1:0]     tap_weight,
    input  logic [WORD_SIZE-1:0]     tap_top,
    input  logic [WORD_SIZE-1:0]     tap_left,
    output logic [WORD_SIZE-1:0]     ru_weight,
    output logic [WORD_SIZE-1:0]     ru_top,
    output logic [WORD_SIZE-1:0]     ru_left,
    output logic [ROWS-1:0]          ru_faulty_row,
    output logic [COLS-1:0]          ru_faulty_col,
    input  logic [WORD_SIZE-1:0]     ru_bottom,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WORD_SIZE-1:0]     res_data,
    output logic [$clog2(ROWS)-1:0]  res_row,
    output logic [$clog2(COLS)-1:0]  res_col,
    output logic                     busy,
    output logic                     miss
);

    localparam int RW = $clog2(ROWS);
    localparam int CW_ = $clog2(COLS);
    localparam int CNTW = (RU_LAT > 1) ? $clog2(RU_LAT) : 1;

    disp_state_t          state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW_-1:0]       col_q, col_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 miss_q, miss_d;
    logic                 fault_ready_q, fault_ready_d;
    logic                 busy_q, busy_d;
    logic [WORD_SIZE-1:0] ru_weight_q, ru_weight_d;
    logic [WORD_SIZE-1:0] ru_top_q, ru_top_d;
    logic [WORD_SIZE-1:0] ru_left_q, ru_left_d;
    logic [ROWS-1:0]      frow_q, frow_d;
    logic [COLS-1:0]      fcol_q, fcol_d;
    logic                 res_valid_q, res_valid_d;
    logic [WORD_SIZE-1:0] res_data_q, res_data_d;
    logic [RW-1:0]        res_row_q, res_row_d;
    logic [CW_-1:0]       res_col_q, res_col_d;
    logic                 tap_hit;

    assign tap_hit = tap_valid && (tap_row == row_q)
                     && (tap_col == col_q);

    // Next-state and next-output computation for the dispatch FSM.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        ru_weight_d = '0;
        ru_top_d    = '0;
        ru_left_d   = '0;
        frow_d      = frow_q;
        fcol_d      = fcol_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        unique case (state_q)
            IDLE: begin
                if (fault_valid) begin
                    row_d   = fault_row;
                    col_d   = fault_col;
                    miss_d  = 1'b0;
                    frow_d  = ROWS'(onehot(6'(fault_row)));
                    fcol_d  = COLS'(onehot(6'(fault_col)));
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (tap_hit) begin
                    ru_weight_d = tap_weight;
                    ru_top_d    = tap_top;
                    ru_left_d   = tap_left;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (tap_hit) miss_d = 1'b1;
                cnt_d   = CNTW'(RU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (tap_hit) miss_d = 1'b1;
                if (cnt_q == '0) begin
                    res_data_d  = ru_bottom;
                    res_row_d   = row_q;
                    res_col_d   = col_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            HOLD: begin
                if (tap_hit) miss_d = 1'b1;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    res_data_d  = '0;
                    res_row_d   = '0;
                    res_col_d   = '0;
                    frow_d      = '0;
                    fcol_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fault_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    // State and registered outputs; reset returns to an idle, ready dispatcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            cnt_q         <= '0;
            miss_q        <= 1'b0;
            fault_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            ru_weight_q   <= '0;
            ru_top_q      <= '0;
            ru_left_q     <= '0;
            frow_q        <= '0;
            fcol_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_row_q     <= '0;
            res_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            miss_q        <= miss_d;
            fault_ready_q <= fault_ready_d;
            busy_q        <= busy_d;
            ru_weight_q   <= ru_weight_d;
            ru_top_q      <= ru_top_d;
            ru_left_q     <= ru_left_d;
            frow_q        <= frow_d;
            fcol_q        <= fcol_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_row_q     <= res_row_d;
            res_col_q     <= res_col_d;
        end
    end

    assign fault_ready   = fault_ready_q;
    assign busy          = busy_q;
    assign miss          = miss_q;
    assign ru_weight     = ru_weight_q;
    assign ru_top        = ru_top_q;
    assign ru_left       = ru_left_q;
    assign ru_faulty_row = frow_q;
    assign ru_faulty_col = fcol_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_row       = res_row_q;
    assign res_col       = res_col_q;

endmodule

// File: tb/tb_recompute_dispatcher.sv
// Directed bench for recompute_dispatcher with a behavioural
// recompute unit (w*l+t through an RU_LAT-deep pipeline).
module tb_recompute_dispatcher;
    import bisr_pkg::*;

    localparam int WS  = 16;
    localparam int LAT = RU_LAT_DEFAULT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fault_valid = 1'b0;
    logic [1:0]    fault_row = '0;
    logic [1:0]    fault_col = '0;
    logic          fault_ready;
    logic          tap_valid = 1'b0;
    logic [1:0]    tap_row = '0;
    logic [1:0]    tap_col = '0;
    logic [WS-1:0] tap_weight = '0;
    logic [WS-1:0] tap_top = '0;
    logic [WS-1:0] tap_left = '0;
    logic [WS-1:0] ru_weight, ru_top, ru_left, ru_bottom;
    logic [3:0]    ru_faulty_row, ru_faulty_col;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [WS-1:0] res_data;
    logic [1:0]    res_row, res_col;
    logic          busy, miss;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    recompute_dispatcher #(
        .WORD_SIZE(WS), .ROWS(4), .COLS(4), .RU_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .fault_valid(fault_valid), .fault_row(fault_row),
        .fault_col(fault_col), .fault_ready(fault_ready),
        .tap_valid(tap_valid), .tap_row(tap_row), .tap_col(tap_col),
        .tap_weight(tap_weight), .tap_top(tap_top), .tap_left(tap_left),
        .ru_weight(ru_weight), .ru_top(ru_top), .ru_left(ru_left),
        .ru_faulty_row(ru_faulty_row), .ru_faulty_col(ru_faulty_col),
        .ru_bottom(ru_bottom),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_col(res_col),
        .busy(busy), .miss(miss)
    );

    // Behavioural recompute unit: LAT-cycle MAC pipeline.
    logic [WS-1:0] pipe [LAT];
    logic [WS-1:0] mac;
    assign mac = WS'(ru_weight * ru_left) + ru_top;
    always_ff @(posedge clk) begin
        pipe[0] <= mac;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ru_bottom = pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic give_fault(input logic [1:0] r, input logic [1:0] c);
        fault_valid = 1'b1;
        fault_row   = r;
        fault_col   = c;
        tick();
        fault_valid = 1'b0;
    endtask

    task automatic give_tap(input logic [1:0] r, input logic [1:0] c,
                            input logic [WS-1:0] w, input logic [WS-1:0] l,
                            input logic [WS-1:0] t);
        tap_valid  = 1'b1;
        tap_row    = r;
        tap_col    = c;
        tap_weight = w;
        tap_left   = l;
        tap_top    = t;
        tick();
        tap_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({fault_ready, busy, res_valid, miss} !== 4'b1000)
            $display("FAIL reset_ctrl got=%b want=1000",
                     {fault_ready, busy, res_valid, miss});
        else passed++;
        total++;
        if ({ru_weight, ru_top, ru_left, ru_faulty_row, ru_faulty_col}
            !== '0)
            $display("FAIL reset_ru got=%h want=0",
                     {ru_weight, ru_top, ru_left});
        else passed++;
        total++;
        if ({res_data, res_row, res_col} !== '0)
            $display("FAIL reset_res got=%h want=0", res_data);
        else passed++;
    endtask

    task automatic test_basic();
        give_fault(2'd2, 2'd1);
        total++;
        if ({fault_ready, busy} !== 2'b01)
            $display("FAIL armed_ctrl got=%b want=01", {fault_ready, busy});
        else passed++;
        total++;
        if ({ru_faulty_row, ru_faulty_col} !== 8'b0100_0010)
            $display("FAIL onehot got=%b want=01000010",
                     {ru_faulty_row, ru_faulty_col});
        else passed++;
        give_tap(2'd2, 2'd1, 16'd3, 16'd5, 16'd7);
        total++;
        if ({ru_weight, ru_left, ru_top} !== {16'd3, 16'd5, 16'd7})
            $display("FAIL issue_ops got=%h want=000300050007",
                     {ru_weight, ru_left, ru_top});
        else passed++;
        tick();
        total++;
        if ({ru_weight, ru_left, ru_top, res_valid} !== '0)
            $display("FAIL wait_ops got=%h/%b want=0/0",
                     ru_weight, res_valid);
        else passed++;
        tick();
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL early_valid got=%b want=0", res_valid);
        else passed++;
        tick();
        total++;
        if ({res_valid, res_data, res_row, res_col}
            !== {1'b1, 16'd22, 2'd2, 2'd1})
            $display("FAIL basic_res got=%b/%0d/%0d/%0d want=1/22/2/1",
                     res_valid, res_data, res_row, res_col);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if ({res_valid, fault_ready, busy, ru_faulty_row} !== 7'b0100000)
            $display("FAIL basic_done got=%b want=0100000",
                     {res_valid, fault_ready, busy, ru_faulty_row});
        else passed++;
    endtask

    task automatic test_wrap();
        res_ready = 1'b1;
        give_fault(2'd0, 2'd3);
        total++;
        if ({ru_faulty_row, ru_faulty_col} !== 8'b0001_1000)
            $display("FAIL wrap_onehot got=%b want=00011000",
                     {ru_faulty_row, ru_faulty_col});
        else passed++;
        give_tap(2'd0, 2'd3, 16'hFFFF, 16'd2, 16'd3);
        tick();
        tick();
        tick();
        total++;
        if ({res_valid, res_data} !== {1'b1, 16'h0001})
            $display("FAIL wrap_res got=%b/%h want=1/0001",
                     res_valid, res_data);
        else passed++;
        tick();
        res_ready = 1'b0;
        total++;
        if ({res_valid, fault_ready} !== 2'b01)
            $display("FAIL wrap_done got=%b want=01",
                     {res_valid, fault_ready});
        else passed++;
    endtask

    task automatic test_filter();
        give_fault(2'd1, 2'd1);
        give_tap(2'd1, 2'd0, 16'd9, 16'd9, 16'd9);
        total++;
        if ({ru_weight, busy} !== {16'd0, 1'b1})
            $display("FAIL filter_a got=%0d/%b want=0/1", ru_weight, busy);
        else passed++;
        give_tap(2'd0, 2'd1, 16'd9, 16'd9, 16'd9);
        total++;
        if (ru_weight !== 16'd0)
            $display("FAIL filter_b got=%0d want=0", ru_weight);
        else passed++;
        give_tap(2'd1, 2'd1, 16'd2, 16'd2, 16'd0);
        total++;
        if (ru_weight !== 16'd2)
            $display("FAIL filter_c got=%0d want=2", ru_weight);
        else passed++;
        tick();
        tick();
        tick();
        total++;
        if ({res_valid, res_data} !== {1'b1, 16'd4})
            $display("FAIL filter_res got=%b/%0d want=1/4",
                     res_valid, res_data);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_hold();
        give_fault(2'd3, 2'd2);
        give_tap(2'd3, 2'd2, 16'd4, 16'd4, 16'd1);
        tick();
        tick();
        tick();
        fault_valid = 1'b1;
        fault_row   = 2'd0;
        fault_col   = 2'd0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({res_valid, res_data, res_row, fault_ready}
                !== {1'b1, 16'd17, 2'd3, 1'b0})
                $display("FAIL hold_%0d got=%b/%0d/%0d/%b want=1/17/3/0",
                         i, res_valid, res_data, res_row, fault_ready);
            else passed++;
            tick();
        end
        fault_valid = 1'b0;
        res_ready   = 1'b1;
        tick();
        res_ready   = 1'b0;
        total++;
        if ({res_valid, busy, fault_ready} !== 3'b001)
            $display("FAIL hold_release got=%b want=001",
                     {res_valid, busy, fault_ready});
        else passed++;
    endtask

    task automatic test_miss();
        give_fault(2'd0, 2'd0);
        give_tap(2'd0, 2'd0, 16'd1, 16'd1, 16'd1);
        tick();
        give_tap(2'd0, 2'd0, 16'd100, 16'd100, 16'd100);
        total++;
        if (miss !== 1'b1)
            $display("FAIL miss_set got=%b want=1", miss);
        else passed++;
        tick();
        total++;
        if ({res_valid, res_data, miss} !== {1'b1, 16'd2, 1'b1})
            $display("FAIL miss_res got=%b/%0d/%b want=1/2/1",
                     res_valid, res_data, miss);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (miss !== 1'b1)
            $display("FAIL miss_sticky got=%b want=1", miss);
        else passed++;
        give_fault(2'd1, 2'd2);
        total++;
        if (miss !== 1'b0)
            $display("FAIL miss_clear got=%b want=0", miss);
        else passed++;
    endtask

    task automatic test_reset_mid();
        give_tap(2'd1, 2'd2, 16'd5, 16'd5, 16'd5);
        tap_valid = 1'b1;
        tick();
        tap_valid = 1'b0;
        total++;
        if ({busy, miss} !== 2'b11)
            $display("FAIL mid_pre got=%b want=11", {busy, miss});
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({fault_ready, busy, res_valid, miss} !== 4'b1000)
            $display("FAIL mid_ctrl got=%b want=1000",
                     {fault_ready, busy, res_valid, miss});
        else passed++;
        total++;
        if ({ru_weight, ru_top, ru_left, ru_faulty_row, ru_faulty_col}
            !== '0)
            $display("FAIL mid_ru got=%h want=0", ru_weight);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({res_valid, busy} !== 2'b00)
                $display("FAIL mid_late_%0d got=%b want=00",
                         i, {res_valid, busy});
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_filter();
        test_hold();
        test_miss();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
